// File: rtl/gf_core_dispatcher.sv
// Core-side consumer of the per-core command/operand FIFOs: gathers operand chunks
// (MS chunk first), launches the field-arithmetic unit and drains its result into FIFO C.
module gf_core_dispatcher #(
  parameter int unsigned DATA = 256,
  parameter logic [2:0]  MUL  = 3'd1,
  parameter logic [2:0]  XOR  = 3'd2,
  parameter logic [2:0]  SQR  = 3'd3,
  parameter logic [2:0]  INV  = 3'd4,
  parameter logic [2:0]  RED  = 3'd5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_empty,
  input  logic [7:0]          cmd_data,
  output logic                cmd_rd_en,
  input  logic                a_empty,
  input  logic [DATA-1:0]     a_data,
  output logic                a_rd_en,
  input  logic                b_empty,
  input  logic [DATA-1:0]     b_data,
  output logic                b_rd_en,
  output logic                exe_start,
  output logic [2:0]          exe_op,
  output logic [3*DATA-1:0]   exe_a,
  output logic [3*DATA-1:0]   exe_b,
  input  logic                exe_done,
  input  logic [3*DATA-1:0]   exe_result,
  input  logic                c_full,
  output logic                c_wr_en,
  output logic [DATA-1:0]     c_data,
  output logic                busy,
  output logic                err,
  output logic [15:0]         op_count
);

  localparam int unsigned WIDE = 3 * DATA;
  localparam int unsigned CW   = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_A    = 3'd1,
    GET_B    = 3'd2,
    EXEC     = 3'd3,
    WAIT_EXE = 3'd4,
    PUT_C    = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [1:0]      n_q, n_d;
  logic [1:0]      idx_q, idx_d;
  logic [WIDE-1:0] exe_a_q, exe_a_d;
  logic [WIDE-1:0] exe_b_q, exe_b_d;
  logic [WIDE-1:0] res_q, res_d;
  logic            start_q, start_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
  logic [CW-1:0]   op_count_q, op_count_d;

  logic [2:0]      cmd_op_c;
  logic [1:0]      cmd_n_c;
  logic            cmd_legal_c;
  logic            binary_c;
  logic            unused_rsvd;

  // Command decode; bits [7:5] are reserved and ignored.
  assign cmd_op_c    = cmd_data[2:0];
  assign cmd_n_c     = cmd_data[4:3];
  assign unused_rsvd = ^cmd_data[7:5];
  assign cmd_legal_c = (cmd_n_c != 2'd0) &&
                       ((cmd_op_c == MUL) || (cmd_op_c == XOR) || (cmd_op_c == SQR) ||
                        (cmd_op_c == INV) || (cmd_op_c == RED));
  assign binary_c    = (op_q == MUL) || (op_q == XOR);

  // Next-state, datapath and FIFO strobes; strobes are gated by rst so nothing pops during reset.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    n_d        = n_q;
    idx_d      = idx_q;
    exe_a_d    = exe_a_q;
    exe_b_d    = exe_b_q;
    res_d      = res_q;
    start_d    = 1'b0;
    err_d      = 1'b0;
    op_count_d = op_count_q;
    cmd_rd_en  = 1'b0;
    a_rd_en    = 1'b0;
    b_rd_en    = 1'b0;
    c_wr_en    = 1'b0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (!cmd_empty) begin
            cmd_rd_en = 1'b1;
            if (!cmd_legal_c) begin
              err_d = 1'b1;
            end else begin
              op_d    = cmd_op_c;
              n_d     = cmd_n_c;
              idx_d   = cmd_n_c - 2'd1;
              exe_a_d = '0;
              exe_b_d = '0;
              state_d = GET_A;
            end
          end
        end
        GET_A: begin
          if (!a_empty) begin
            a_rd_en = 1'b1;
            exe_a_d[DATA*32'(idx_q) +: DATA] = a_data;
            if (idx_q != 2'd0) begin
              idx_d = idx_q - 2'd1;
            end else if (binary_c) begin
              idx_d   = n_q - 2'd1;
              state_d = GET_B;
            end else begin
              start_d = 1'b1;
              state_d = EXEC;
            end
          end
        end
        GET_B: begin
          if (!b_empty) begin
            b_rd_en = 1'b1;
            exe_b_d[DATA*32'(idx_q) +: DATA] = b_data;
            if (idx_q != 2'd0) begin
              idx_d = idx_q - 2'd1;
            end else begin
              start_d = 1'b1;
              state_d = EXEC;
            end
          end
        end
        EXEC: begin
          state_d = WAIT_EXE;
        end
        WAIT_EXE: begin
          if (exe_done) begin
            res_d   = exe_result;
            idx_d   = n_q - 2'd1;
            state_d = PUT_C;
          end
        end
        PUT_C: begin
          if (!c_full) begin
            c_wr_en = 1'b1;
            if (idx_q != 2'd0) begin
              idx_d = idx_q - 2'd1;
            end else begin
              op_count_d = (op_count_q == 16'hFFFF) ? op_count_q : op_count_q + 16'd1;
              state_d    = IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers; synchronous reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= '0;
      n_q        <= '0;
      idx_q      <= '0;
      exe_a_q    <= '0;
      exe_b_q    <= '0;
      res_q      <= '0;
      start_q    <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      exe_a_q    <= exe_a_d;
      exe_b_q    <= exe_b_d;
      res_q      <= res_d;
      start_q    <= start_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      op_count_q <= op_count_d;
    end
  end

  assign exe_start = start_q;
  assign exe_op    = op_q;
  assign exe_a     = exe_a_q;
  assign exe_b     = exe_b_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign op_count  = op_count_q;
  assign c_data    = res_q[DATA*32'(idx_q) +: DATA];

endmodule
